uart_frame_upload: RTL and testbench
====================================

// Module: uart_frame_upload
// PURPOSE
//  Buffers bytes from the acquisition logic and ships them to the host as one framed UART packet per uart_send.
//  Frame: HEADER, LEN (bytes in FIFO, latched at start), payload bytes, then optional CHECKSUM.
//  Successor to the fixed 8N1/230400 uploader; FIFO depth, baud divisor, header and stop bits are parameters.
//  Integrated synchronous FIFO and TX serializer; sits between the frame assembler and the host TX pin.
// PARAMETERS
//  CLK_FREQ   50_000_000  clock frequency in Hz
//  BAUD_RATE  230400      line rate; DIV = CLK_FREQ/BAUD_RATE, integer-truncated (217 at defaults)
//  FIFO_DEPTH 128         payload FIFO entries, 2..255, power of two
//  HEADER     8'hA5       first byte of every frame
//  STOP_BITS  1           1 or 2 stop bits
// PORTS
//  clk_50m         in   1              system clock
//  rst             in   1              asynchronous reset, active-high
//  wr_data         in   8              payload byte, written when wr_en=1 and fifo_full=0
//  wr_en           in   1              FIFO write strobe, one byte per cycle
//  fifo_full       out  1              FIFO holds FIFO_DEPTH bytes
//  fifo_level      out  $clog2(D)+1    current FIFO occupancy
//  uart_send       in   1              start-frame request; 1-cycle pulse or level
//  uart_rdy        out  1              1 in IDLE only
//  uart_send_done  out  1              1-cycle pulse after last stop bit of the frame
//  tx              out  1              serial line, idle high, LSB first, 8 data bits, no parity
// BEHAVIOUR
//  Reset: tx=1, uart_rdy=1, uart_send_done=0, fifo_full=0, fifo_level=0, FSM=IDLE, FIFO pointers cleared.
//  Reset mid-frame aborts at once: tx returns high in the same cycle; the partial frame is not resumed.
//  FSM: IDLE -> HDR -> LEN -> PAY -> [CSUM] -> DONE -> IDLE.
//   IDLE: on uart_send=1, latch len=fifo_level and clear sum; go to HDR next cycle. Start bit begins the following cycle.
//   HDR/LEN/CSUM/PAY: each sends one character: start(0), d0..d7, STOP_BITS x 1. Every bit lasts exactly DIV cycles.
//   PAY: pops one FIFO byte per character; the pop occurs on the cycle its start bit begins. Moves on after len bytes.
//   LEN=0 skips PAY entirely.
//   DONE: uart_send_done=1 for exactly one cycle, then IDLE; uart_rdy rises that same cycle.
//  Characters are back-to-back: the next start bit immediately follows the last stop bit, with no idle gap.
//  uart_send is ignored while uart_rdy=0; no queuing. Holding uart_send high sends frames back to back.
//  Bytes written during a frame stay in the FIFO for the next frame; the frame length stays the latched len.
//  Write while full: byte dropped, FIFO unchanged. Write and pop in the same cycle: level unchanged, both performed.
//  FIFO pointers wrap modulo FIFO_DEPTH. fifo_level and fifo_full are registered and update the cycle after the write/pop.
//  sum = 8-bit mod-256 sum of payload bytes only; carries are discarded.
// CONFIGURATION
//  UART_CHECKSUM_EN defined: CSUM state sends (~sum + 1) & 8'hFF after the payload, so that payload+CSUM = 0 mod 256.
//  UART_CHECKSUM_EN undefined: no CSUM state; PAY (or LEN when len=0) goes straight to DONE. The sum logic is removed.
// TESTING
//  Defaults assumed; bit period = 217 clk_50m cycles, character = 2170 cycles.
//  T1 reset: assert rst mid-payload -> tx=1 in the same cycle, uart_rdy=1, fifo_level=0; next frame is clean.
//  T2 basic frame: write 11,22,33; pulse uart_send -> tx A5,03,11,22,33 (+9A with checksum);
//     uart_send_done pulses once, 5x2170 cycles (6x2170 with checksum) after the first start bit.
//  T3 empty frame: uart_send with FIFO empty -> A5,00 (+00 with checksum); done pulse; FIFO untouched.
//  T4 full/overflow: write 130 bytes -> fifo_full=1 and level=128 after byte 128; bytes 129-130 dropped;
//     LEN=0x80 sent; frame carries bytes 1..128 in order.
//  T5 concurrent: write 2 bytes while a 3-byte frame is in PAY -> frame LEN=03; level afterwards=2;
//     uart_send held low during the frame is ignored.
//  T6 back-to-back: hold uart_send high with 1 byte queued per frame -> consecutive frames with no idle gap;
//     one done pulse per frame; STOP_BITS=2 run checks 2 stop-bit periods.

Source files
------------

// File: rtl/uart_frame_upload.sv
// Framed UART uploader: payload FIFO plus serializer sending HEADER, LEN, payload[, CHECKSUM].
// Define UART_CHECKSUM_EN to append a two's-complement checksum character to each frame.
module uart_frame_upload #(
  parameter int         CLK_FREQ   = 50_000_000,
  parameter int         BAUD_RATE  = 230400,
  parameter int         FIFO_DEPTH = 128,
  parameter logic [7:0] HEADER     = 8'hA5,
  parameter int         STOP_BITS  = 1
) (
  input  logic                          clk_50m,
  input  logic                          rst,
  input  logic [7:0]                    wr_data,
  input  logic                          wr_en,
  output logic                          fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  input  logic                          uart_send,
  output logic                          uart_rdy,
  output logic                          uart_send_done,
  output logic                          tx
);

  localparam int DIV   = CLK_FREQ / BAUD_RATE;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int LW    = AW + 1;
  localparam int CW    = $clog2(DIV + 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
  localparam logic [3:0]    BIT_LAST = 4'(9 + STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_LEN, S_PAY,
`ifdef UART_CHECKSUM_EN
    S_CSUM,
`endif
    S_DONE
  } state_t;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q, level_d;
  logic          full_q;
  logic          push, pop;

  assign push = wr_en && !full_q;

  // NOTE: payload storage is deliberately not reset; pointers and level alone define valid entries.
  always_ff @(posedge clk_50m) begin
    if (push) mem[wr_ptr_q] <= wr_data;
  end

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
      full_q  <= (level_d == LW'(FIFO_DEPTH));
    end
  end

  assign fifo_level = level_q;
  assign fifo_full  = full_q;

  state_t        state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [3:0]    bit_q, bit_d;
  logic [7:0]    byte_q, byte_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] cnt_q, cnt_d;
`ifdef UART_CHECKSUM_EN
  logic [7:0]    sum_q, sum_d;
`endif
  logic          bit_end, char_end, start_cyc, sending;

  assign sending   = (state_q != S_IDLE) && (state_q != S_DONE);
  assign bit_end   = (baud_q == DIV_LAST);
  assign char_end  = bit_end && (bit_q == BIT_LAST);
  assign start_cyc = (baud_q == '0) && (bit_q == '0);

  // NOTE: every output of this block is defaulted first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
`ifdef UART_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    if (sending) begin
      baud_d = bit_end ? '0 : baud_q + 1'b1;
      if (bit_end) bit_d = char_end ? 4'd0 : bit_q + 4'd1;
    end
    case (state_q)
      S_IDLE: if (uart_send) begin
        state_d = S_HDR;
        byte_d  = HEADER;
        len_d   = level_q;
        cnt_d   = '0;
        baud_d  = '0;
        bit_d   = '0;
`ifdef UART_CHECKSUM_EN
        sum_d   = '0;
`endif
      end
      S_HDR: if (char_end) begin
        state_d = S_LEN;
        byte_d  = 8'(len_q);
      end
      S_LEN: if (char_end) begin
        if (len_q != '0) begin
          state_d = S_PAY;
        end else begin
`ifdef UART_CHECKSUM_EN
          state_d = S_CSUM;
          byte_d  = ~sum_q + 8'd1;
`else
          state_d = S_DONE;
`endif
        end
      end
      S_PAY: begin
        // The byte is popped as its start bit goes out; data bits follow from byte_q.
        if (start_cyc) begin
          pop    = 1'b1;
          byte_d = mem[rd_ptr_q];
          cnt_d  = cnt_q + 1'b1;
`ifdef UART_CHECKSUM_EN
          sum_d  = sum_q + mem[rd_ptr_q];
`endif
        end
        if (char_end && cnt_q == len_q) begin
`ifdef UART_CHECKSUM_EN
          state_d = S_CSUM;
          byte_d  = ~sum_q + 8'd1;
`else
          state_d = S_DONE;
`endif
        end
      end
`ifdef UART_CHECKSUM_EN
      S_CSUM: if (char_end) state_d = S_DONE;
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
`ifdef UART_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
`ifdef UART_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  always_comb begin
    tx = 1'b1;
    if (sending) begin
      if (bit_q == 4'd0)      tx = 1'b0;
      else if (bit_q <= 4'd8) tx = byte_q[3'(bit_q - 4'd1)];
    end
  end

  assign uart_rdy       = (state_q == S_IDLE);
  assign uart_send_done = (state_q == S_DONE);

endmodule

// File: tb/tb_uart_frame_upload.sv
// Scoreboard bench for uart_frame_upload: two instances (1 and 2 stop bits), UART decoders pop expected bytes.
module tb_uart_frame_upload;

  localparam int DIV = 4;            // 1000 / 230 truncated
  localparam int CH1 = 10 * DIV;
  localparam int CH2 = 11 * DIV;
`ifdef UART_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  typedef struct {
    logic [7:0] data;
    bit         first;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] wr_data1, wr_data2;
  logic       wr_en1, wr_en2, send1, send2;
  logic       full1, full2, rdy1, rdy2, done1, done2, tx1, tx2;
  logic [7:0] level1;
  logic [2:0] level2;

  int vectors = 0, miscompares = 0;
  int cyc = 0, last_rst_cyc = 0;
  int hdr1_cyc = 0, hdr2_cyc = 0, done1_cyc = 0, done2_cyc = 0;
  int done1_cnt = 0, done2_cnt = 0;
  logic prev_done1 = 1'b0, prev_done2 = 1'b0;
  exp_t q1[$], q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  uart_frame_upload #(.CLK_FREQ(1000), .BAUD_RATE(230), .FIFO_DEPTH(128), .HEADER(8'hA5), .STOP_BITS(1)) u_dut1 (
    .clk_50m(clk), .rst(rst), .wr_data(wr_data1), .wr_en(wr_en1), .fifo_full(full1),
    .fifo_level(level1), .uart_send(send1), .uart_rdy(rdy1), .uart_send_done(done1), .tx(tx1));

  uart_frame_upload #(.CLK_FREQ(1000), .BAUD_RATE(230), .FIFO_DEPTH(4), .HEADER(8'hA5), .STOP_BITS(2)) u_dut2 (
    .clk_50m(clk), .rst(rst), .wr_data(wr_data2), .wr_en(wr_en2), .fifo_full(full2),
    .fifo_level(level2), .uart_send(send2), .uart_rdy(rdy2), .uart_send_done(done2), .tx(tx2));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic txs(input int which);
    return (which != 0) ? tx2 : tx1;
  endfunction

  task automatic push(input int which, input logic [7:0] d, input bit first);
    exp_t e;
    e.data  = d;
    e.first = first;
    if (which == 0) q1.push_back(e);
    else            q2.push_back(e);
  endtask

  // Entered on the negedge where the start bit was first seen; samples at bit centres.
  task automatic rx_char(input int which, input int stops, output logic [7:0] d, output int t0);
    t0 = cyc;
    repeat (DIV / 2) @(negedge clk);
    if (last_rst_cyc < t0) check($sformatf("rx%0d_start_bit", which + 1), txs(which), 1'b0);
    for (int i = 0; i < 8; i++) begin
      repeat (DIV) @(negedge clk);
      d[i] = txs(which);
    end
    for (int s = 0; s < stops; s++) begin
      repeat (DIV) @(negedge clk);
      check($sformatf("rx%0d_stop_bit", which + 1), txs(which), 1'b1);
    end
  endtask

  task automatic run_monitor(input int which);
    logic [7:0] d;
    int   t0, prev_t0, stops, ch;
    exp_t e;
    stops   = (which != 0) ? 2 : 1;
    ch      = (9 + stops) * DIV;
    prev_t0 = 0;
    forever begin
      @(negedge clk);
      if (!rst && txs(which) === 1'b0) begin
        rx_char(which, stops, d, t0);
        if (last_rst_cyc >= t0) continue;
        if (((which != 0) ? q2.size() : q1.size()) == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL rx%0d_unexpected: got %02h, no byte expected", which + 1, d);
        end else begin
          e = (which != 0) ? q2.pop_front() : q1.pop_front();
          check($sformatf("rx%0d_byte", which + 1), d, e.data);
          if (e.first) begin
            if (which != 0) hdr2_cyc = t0;
            else            hdr1_cyc = t0;
          end else begin
            check($sformatf("rx%0d_char_spacing", which + 1), t0 - prev_t0, ch);
          end
          prev_t0 = t0;
        end
      end
    end
  endtask

  initial run_monitor(0);
  initial run_monitor(1);

  always @(negedge clk) begin
    if (done1) begin
      check("done1_single_cycle", prev_done1, 1'b0);
      done1_cnt++;
      done1_cyc = cyc;
    end
    if (done2) begin
      check("done2_single_cycle", prev_done2, 1'b0);
      done2_cnt++;
      done2_cyc = cyc;
    end
    prev_done1 = done1;
    prev_done2 = done2;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input int which, input logic [7:0] d);
    if (which == 0) begin wr_en1 = 1'b1; wr_data1 = d; end
    else            begin wr_en2 = 1'b1; wr_data2 = d; end
    @(posedge clk);
    #1;
    wr_en1 = 1'b0;
    wr_en2 = 1'b0;
  endtask

  task automatic pulse_send1();
    send1 = 1'b1;
    @(posedge clk);
    #1;
    send1 = 1'b0;
  endtask

  task automatic wait_done(input int which, input int n, input int budget);
    int k = 0;
    while (((which != 0) ? done2_cnt : done1_cnt) < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    #1;
    check($sformatf("done%0d_count", which + 1), (which != 0) ? done2_cnt : done1_cnt, n);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, %0d vectors applied", vectors);
    $fatal(1);
  end

  initial begin : stim
    int d5;
    bit found;
    rst = 1'b1;
    wr_en1 = 1'b0; wr_en2 = 1'b0; send1 = 1'b0; send2 = 1'b0;
    wr_data1 = '0; wr_data2 = '0;
    idle(3);
    check("rst_tx", tx1, 1'b1);
    check("rst_rdy", rdy1, 1'b1);
    check("rst_done", done1, 1'b0);
    check("rst_full", full1, 1'b0);
    check("rst_level", level1, 0);
    rst = 1'b0;
    idle(2);

    // Basic frame: 11,22,33.
    wr(0, 8'h11); wr(0, 8'h22); wr(0, 8'h33);
    check("t2_level", level1, 3);
    push(0, 8'hA5, 1); push(0, 8'h03, 0); push(0, 8'h11, 0); push(0, 8'h22, 0); push(0, 8'h33, 0);
    if (CS != 0) push(0, 8'h9A, 0);
    pulse_send1();
    check("t2_rdy_busy", rdy1, 1'b0);
    wait_done(0, 1, 2000);
    check("t2_done_timing", done1_cyc - hdr1_cyc, (5 + CS) * CH1);
    idle(2);
    check("t2_level_after", level1, 0);
    check("t2_rdy_after", rdy1, 1'b1);

    // Empty frame.
    push(0, 8'hA5, 1); push(0, 8'h00, 0);
    if (CS != 0) push(0, 8'h00, 0);
    pulse_send1();
    wait_done(0, 2, 2000);
    check("t3_done_timing", done1_cyc - hdr1_cyc, (2 + CS) * CH1);
    check("t3_level", level1, 0);

    // Fill to 128, overflow by 2.
    for (int i = 0; i < 130; i++) begin
      wr(0, 8'(i + 1));
      if (i == 126) begin
        check("t4_level_127", level1, 127);
        check("t4_not_full_127", full1, 1'b0);
      end
      if (i == 127) begin
        check("t4_level_128", level1, 128);
        check("t4_full_128", full1, 1'b1);
      end
    end
    check("t4_level_after_drop", level1, 128);
    check("t4_full_after_drop", full1, 1'b1);
    push(0, 8'hA5, 1); push(0, 8'h80, 0);
    for (int i = 1; i <= 128; i++) push(0, 8'(i), 0);
    if (CS != 0) push(0, 8'hC0, 0);
    pulse_send1();
    wait_done(0, 3, 10000);
    check("t4_level_empty", level1, 0);
    check("t4_full_clear", full1, 1'b0);

    // Writes and an ignored send during a 3-byte frame.
    wr(0, 8'h01); wr(0, 8'h80); wr(0, 8'hFF);
    push(0, 8'hA5, 1); push(0, 8'h03, 0); push(0, 8'h01, 0); push(0, 8'h80, 0); push(0, 8'hFF, 0);
    if (CS != 0) push(0, 8'h80, 0);
    pulse_send1();
    idle(2 * CH1 + 5);
    wr(0, 8'h5A); wr(0, 8'hC3);
    pulse_send1();
    wait_done(0, 4, 2000);
    idle(3 * CH1);
    check("t5_level", level1, 2);
    check("t5_no_extra_frame", done1_cnt, 4);

    // Back-to-back frames with uart_send held high.
    push(0, 8'hA5, 1); push(0, 8'h02, 0); push(0, 8'h5A, 0); push(0, 8'hC3, 0);
    if (CS != 0) push(0, 8'hE3, 0);
    push(0, 8'hA5, 1); push(0, 8'h01, 0); push(0, 8'h77, 0);
    if (CS != 0) push(0, 8'h89, 0);
    send1 = 1'b1;
    idle(CH1);
    wr(0, 8'h77);
    wait_done(0, 5, 2000);
    d5 = done1_cyc;
    idle(4);
    send1 = 1'b0;
    wait_done(0, 6, 2000);
    check("t6_no_idle_gap", (hdr1_cyc > d5) && (hdr1_cyc - d5 <= DIV), 1'b1);
    idle(2 * CH1);
    check("t6_frame_count", done1_cnt, 6);
    check("t6_level", level1, 0);

    // Two stop bits, depth 4: overflow, pointer wrap, back-to-back.
    wr(1, 8'h10); wr(1, 8'h20); wr(1, 8'h30); wr(1, 8'h40); wr(1, 8'h50);
    check("s2_full", full2, 1'b1);
    check("s2_level", level2, 4);
    push(1, 8'hA5, 1); push(1, 8'h04, 0);
    push(1, 8'h10, 0); push(1, 8'h20, 0); push(1, 8'h30, 0); push(1, 8'h40, 0);
    if (CS != 0) push(1, 8'h60, 0);
    push(1, 8'hA5, 1); push(1, 8'h01, 0); push(1, 8'h99, 0);
    if (CS != 0) push(1, 8'h67, 0);
    send2 = 1'b1;
    idle(3 * CH2);
    wr(1, 8'h99);
    wait_done(1, 1, 2000);
    check("s2_done_timing", done2_cyc - hdr2_cyc, (6 + CS) * CH2);
    idle(4);
    send2 = 1'b0;
    wait_done(1, 2, 2000);
    idle(2 * CH2);
    check("s2_frame_count", done2_cnt, 2);
    check("s2_level", level2, 0);

    // Reset mid-payload, then a clean frame.
    wr(0, 8'hDE); wr(0, 8'hAD); wr(0, 8'hBE);
    push(0, 8'hA5, 1); push(0, 8'h03, 0);
    pulse_send1();
    idle(2 * CH1 + 5 * DIV);
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clk);
      if (tx1 === 1'b0) found = 1'b1;
    end
    check("t1_tx_low_in_payload", found, 1'b1);
    #2;
    rst = 1'b1;
    last_rst_cyc = cyc;
    #1;
    check("t1_tx_high_same_cycle", tx1, 1'b1);
    check("t1_rdy", rdy1, 1'b1);
    check("t1_level", level1, 0);
    check("t1_full", full1, 1'b0);
    idle(2);
    rst = 1'b0;
    idle(2 * CH1);
    check("t1_no_done_on_abort", done1_cnt, 6);
    wr(0, 8'h42);
    push(0, 8'hA5, 1); push(0, 8'h01, 0); push(0, 8'h42, 0);
    if (CS != 0) push(0, 8'hBE, 0);
    pulse_send1();
    wait_done(0, 7, 2000);
    check("t1_clean_timing", done1_cyc - hdr1_cyc, (3 + CS) * CH1);
    idle(CH1);
    check("q1_drained", q1.size(), 0);
    check("q2_drained", q2.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
